lms_adapt_engine: RTL and testbench

// - Parametrised LMS coefficient-update engine for the FSE equaliser. Computes e = d_hat - y
//   and updates Nw taps as w[i] += mu*e*x_r[i], with saturating accumulators.
// - Adds to the prior update logic: input valid qualifier, programmable update decimation,
//   and a 2-stage mu schedule run by an FSM (ACQ -> TRACK).
// - Adds freeze, a debug coefficient load, and registered error/state outputs for the debug unit.

---
 rtl/lms_adapt_engine.sv | 228 ++++++++++++++++++++++
 tb/tb_lms_adapt_engine.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lms_adapt_engine.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : lms_adapt_engine                                             |
// | Description : LMS coefficient-update engine for the FSE equaliser.         |
// |               e = d_hat - y, w[i] += mu*e*x_r[i] with saturating           |
// |               accumulators, update decimation, ACQ->TRACK mu schedule,     |
// |               freeze, debug coefficient load and registered debug outputs. |
// | Option      : LMS_LEAKAGE_EN - adds the leakage term w -= w >>> LEAK_SH.   |
// | Ports       : clkA      in  clock, rising edge                             |
// |               reset     in  asynchronous active-low reset                  |
// |               i_valid   in  x/y/d qualifier                                |
// |               x         in  signed input sample (NBX)                      |
// |               y         in  signed equaliser output (NBY)                  |
// |               d         in  slicer decision, 1 = +1.0, 0 = -1.0            |
// |               i_freeze  in  hold taps, delay line and counters             |
// |               i_load    in  one-cycle pulse, load i_coeffs into the taps   |
// |               i_coeffs  in  debug taps, tap k at [NBW*(k+1)-1 -: NBW]      |
// |               coeff     out registered saturated taps, same packing        |
// |               e_out     out registered error (NBY+1)                       |
// |               o_state   out 00 ACQ, 01 TRACK, 10 FREEZE                    |
// |               o_sat     out sticky accumulator-clamp flag                  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module lms_adapt_engine #(
   parameter int NBX       = 8,
   parameter int NBFX      = 5,
   parameter int NBY       = 8,
   parameter int NBFY      = 5,
   parameter int NW        = 9,
   parameter int NBW       = 7,
   parameter int NBFW      = 5,
   parameter int NBACC     = 24,
   parameter int NBFACC    = 20,
   parameter int MU_ACQ_SH = 3,
   parameter int MU_TRK_SH = 6,
   parameter int ACQ_LEN   = 600,
   parameter int UPD_DIV   = 2
`ifdef LMS_LEAKAGE_EN
   ,
   parameter int LEAK_SH   = 12
`endif
) (
   input  logic                  clkA,
   input  logic                  reset,
   input  logic                  i_valid,
   input  logic signed [NBX-1:0] x,
   input  logic signed [NBY-1:0] y,
   input  logic                  d,
   input  logic                  i_freeze,
   input  logic                  i_load,
   input  logic [NW*NBW-1:0]     i_coeffs,
   output logic [NW*NBW-1:0]     coeff,
   output logic signed [NBY:0]   e_out,
   output logic [1:0]            o_state,
   output logic                  o_sat
);

   localparam int PW       = NBY + 1 + NBX;               // e*x product width
   localparam int ALIGN_SH = NBFACC - NBFX - NBFY;
   localparam int PALW     = PW + ALIGN_SH;
   // one guard bit above the wider operand so overflow is seen before clamping
   localparam int SUMW     = ((PALW > NBACC) ? PALW : NBACC) + 1;
   localparam int OUT_SH   = NBFACC - NBFW;
   localparam int TW       = NBACC - OUT_SH;
   localparam int CENTER   = NW / 2;
   localparam int DCW      = (UPD_DIV > 1) ? $clog2(UPD_DIV) : 1;
   localparam int ACW      = $clog2(ACQ_LEN + 1);

   localparam logic [DCW-1:0]          DEC_LAST = DCW'(UPD_DIV - 1);
   localparam logic [ACW-1:0]          ACQ_LAST = ACW'(ACQ_LEN - 1);
   localparam logic signed [NBY:0]     DHAT     = (NBY+1)'(1 << NBFY);
   localparam logic signed [NBACC-1:0] W_ONE    = NBACC'(1 << NBFACC);
   localparam logic [NBW-1:0]          TAP_ONE  = NBW'(1 << NBFW);
   localparam logic signed [SUMW-1:0]  ACC_MAX  = SUMW'((1 << (NBACC-1)) - 1);
   localparam logic signed [SUMW-1:0]  ACC_MIN  = SUMW'(-(1 << (NBACC-1)));
   localparam logic signed [TW-1:0]    TAP_MAX  = TW'((1 << (NBW-1)) - 1);
   localparam logic signed [TW-1:0]    TAP_MIN  = TW'(-(1 << (NBW-1)));

   typedef enum logic [1:0] {
      ST_ACQ    = 2'b00,
      ST_TRACK  = 2'b01,
      ST_FREEZE = 2'b10
   } state_t;

   // state_q is the visible state; mode_q is the ACQ/TRACK mode that FREEZE resumes to
   state_t                  state_q, mode_q;
   logic [ACW-1:0]          acq_cnt_q;
   logic [DCW-1:0]          dec_cnt_q;
   logic signed [NBX-1:0]   xr_q [NW];
   logic signed [NBY:0]     e_q;
   logic                    sat_q;

   logic signed [NBY:0]     y_ext, dhat, e_d;
   logic                    shift_en, dec_wrap, upd_fire, acq_done;
   logic [NW-1:0]           clamp;

   assign y_ext    = (NBY+1)'(y);
   assign dhat     = d ? DHAT : -DHAT;
   assign e_d      = dhat - y_ext;

   assign shift_en = i_valid & ~i_freeze;
   assign dec_wrap = (dec_cnt_q == DEC_LAST);
   // load wins over an update landing in the same cycle
   assign upd_fire = shift_en & ~i_load & dec_wrap;
   assign acq_done = upd_fire & (mode_q == ST_ACQ) & (acq_cnt_q == ACQ_LAST);

   // Mode / freeze state machine with ACQ update counter
   always_ff @(posedge clkA or negedge reset) begin
      if (!reset) begin
         state_q   <= ST_ACQ;
         mode_q    <= ST_ACQ;
         acq_cnt_q <= '0;
      end else if (i_load) begin
         mode_q  <= ST_TRACK;
         state_q <= i_freeze ? ST_FREEZE : ST_TRACK;
      end else begin
         if (upd_fire && (mode_q == ST_ACQ))
            acq_cnt_q <= acq_cnt_q + 1'b1;
         if (acq_done)
            mode_q <= ST_TRACK;
         if (i_freeze)
            state_q <= ST_FREEZE;
         else if (acq_done)
            state_q <= ST_TRACK;
         else
            state_q <= mode_q;
      end
   end

   // Decimation counter, error register, sticky saturation flag
   always_ff @(posedge clkA or negedge reset) begin
      if (!reset) begin
         dec_cnt_q <= '0;
         e_q       <= '0;
         sat_q     <= 1'b0;
      end else begin
         if (i_load)
            dec_cnt_q <= '0;
         else if (shift_en)
            dec_cnt_q <= dec_wrap ? '0 : dec_cnt_q + 1'b1;
         if (i_valid)
            e_q <= e_d;
         if (i_load)
            sat_q <= 1'b0;
         else if (upd_fire && (|clamp))
            sat_q <= 1'b1;
      end
   end

   // Input delay line; the update reads the pre-shift contents
   always_ff @(posedge clkA or negedge reset) begin
      if (!reset) begin
         for (int k = 0; k < NW; k++)
            xr_q[k] <= '0;
      end else if (shift_en) begin
         xr_q[0] <= x;
         for (int k = 1; k < NW; k++)
            xr_q[k] <= xr_q[k-1];
      end
   end

   for (genvar k = 0; k < NW; k++) begin : g_tap
      logic signed [PW-1:0]    prod;
      logic signed [SUMW-1:0]  p_al, w_ext, sum;
      logic signed [NBACC-1:0] w_q, w_new, w_ld;
      logic signed [NBW-1:0]   ld_tap;
      logic signed [TW-1:0]    w_trunc;
      logic [NBW-1:0]          tap_sat, tap_q;
      logic                    clamp_k;

      assign ld_tap   = i_coeffs[NBW*(k+1)-1 -: NBW];
      assign clamp[k] = clamp_k;
      assign coeff[NBW*(k+1)-1 -: NBW] = tap_q;

      always_comb begin
         prod  = PW'(e_d) * PW'(xr_q[k]);
         p_al  = SUMW'(prod) <<< ALIGN_SH;
         // arithmetic shift gives floor rounding of mu*e*x
         if (mode_q == ST_ACQ)
            p_al = p_al >>> MU_ACQ_SH;
         else
            p_al = p_al >>> MU_TRK_SH;
         w_ext = SUMW'(w_q);
`ifdef LMS_LEAKAGE_EN
         sum   = w_ext - (w_ext >>> LEAK_SH) + p_al;
`else
         sum   = w_ext + p_al;
`endif
         clamp_k = 1'b0;
         w_new   = sum[NBACC-1:0];
         if (sum > ACC_MAX) begin
            w_new   = ACC_MAX[NBACC-1:0];
            clamp_k = 1'b1;
         end else if (sum < ACC_MIN) begin
            w_new   = ACC_MIN[NBACC-1:0];
            clamp_k = 1'b1;
         end
         w_ld = NBACC'(ld_tap);
         w_ld = w_ld <<< OUT_SH;
         // floor-truncate to NBFW fractional bits, then clamp to NBW
         w_trunc = w_q[NBACC-1:OUT_SH];
         tap_sat = w_trunc[NBW-1:0];
         if (w_trunc > TAP_MAX)
            tap_sat = TAP_MAX[NBW-1:0];
         else if (w_trunc < TAP_MIN)
            tap_sat = TAP_MIN[NBW-1:0];
      end

      always_ff @(posedge clkA or negedge reset) begin
         if (!reset) begin
            w_q   <= (k == CENTER) ? W_ONE : '0;
            tap_q <= (k == CENTER) ? TAP_ONE : '0;
         end else begin
            if (i_load)
               w_q <= w_ld;
            else if (upd_fire)
               w_q <= w_new;
            tap_q <= tap_sat;
         end
      end
   end

   assign e_out   = e_q;
   assign o_state = state_q;
   assign o_sat   = sat_q;

endmodule
`default_nettype wire

// File: tb/tb_lms_adapt_engine.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_lms_adapt_engine                                          |
// | Description : Self-checking bench for lms_adapt_engine. A behavioural      |
// |               model pushes expected outputs into a queue for every driven  |
// |               cycle; they are popped and compared after the clock edge.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_lms_adapt_engine;

   localparam int NW = 9;
   localparam int NBW = 7;
   localparam logic [62:0] RST_COEFF = 63'h20 << 28;

   logic        clkA = 1'b0;
   logic        reset;
   logic        i_valid, d, i_freeze, i_load;
   logic [7:0]  x, y;
   logic [62:0] i_coeffs, coeff;
   logic [8:0]  e_out;
   logic [1:0]  o_state;
   logic        o_sat;

   always #5 clkA = ~clkA;

   lms_adapt_engine dut (
      .clkA     (clkA),
      .reset    (reset),
      .i_valid  (i_valid),
      .x        (x),
      .y        (y),
      .d        (d),
      .i_freeze (i_freeze),
      .i_load   (i_load),
      .i_coeffs (i_coeffs),
      .coeff    (coeff),
      .e_out    (e_out),
      .o_state  (o_state),
      .o_sat    (o_sat)
   );

   typedef struct {
      logic [62:0] c;
      logic [8:0]  e;
      logic [1:0]  s;
      logic        t;
   } exp_t;

   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   // behavioural model state
   longint mw [NW];
   int     mx [NW];
   int     mdec, macq;
   bit     mtrack, mfrz, msat;
   logic [8:0] meout;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [62:0] model_coeff();
      logic [62:0] r;
      longint t;
      r = '0;
      for (int k = 0; k < NW; k++) begin
         t = mw[k] >>> 15;
         if (t > 63) t = 63;
         if (t < -64) t = -64;
         r[k*NBW +: NBW] = t[6:0];
      end
      return r;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < NW; k++) begin
         mw[k] = 0;
         mx[k] = 0;
      end
      mw[4]  = longint'(1) << 20;
      mdec   = 0;
      macq   = 0;
      mtrack = 0;
      mfrz   = 0;
      msat   = 0;
      meout  = '0;
   endtask

   task automatic model_step(input bit v, input logic [7:0] xx, input logic [7:0] yy,
                             input bit dd, input bit fz, input bit l, input logic [62:0] cf);
      exp_t   ex;
      int     e, sh;
      bit     upd;
      longint p, pa, s, tv;
      logic [6:0] ct;
      ex.c = model_coeff();            // coeff shows the taps from before this edge
      e    = (dd ? 32 : -32) - int'($signed(yy));
      if (v) meout = e[8:0];
      upd  = v && !fz && !l && (mdec == 1);
      sh   = mtrack ? 6 : 3;
      if (l) begin
         for (int k = 0; k < NW; k++) begin
            ct = cf[k*NBW +: NBW];
            tv = longint'($signed(ct));
            mw[k] = tv * 32768;
         end
         msat   = 0;
         mdec   = 0;
         mtrack = 1;
      end else if (upd) begin
         for (int k = 0; k < NW; k++) begin
            p  = longint'(e) * longint'(mx[k]);
            pa = (p * 1024) >>> sh;
`ifdef LMS_LEAKAGE_EN
            s  = mw[k] - (mw[k] >>> 12) + pa;
`else
            s  = mw[k] + pa;
`endif
            if (s > 8388607) begin s = 8388607; msat = 1; end
            if (s < -8388608) begin s = -8388608; msat = 1; end
            mw[k] = s;
         end
         if (!mtrack) begin
            macq++;
            if (macq == 600) mtrack = 1;
         end
      end
      if (v && !fz && !l) mdec = (mdec == 1) ? 0 : mdec + 1;
      if (v && !fz) begin
         for (int k = NW-1; k > 0; k--) mx[k] = mx[k-1];
         mx[0] = int'($signed(xx));
      end
      mfrz = fz;
      ex.e = meout;
      ex.s = mfrz ? 2'b10 : (mtrack ? 2'b01 : 2'b00);
      ex.t = msat;
      sb.push_back(ex);
   endtask

   task automatic step(input bit v, input logic [7:0] xx, input logic [7:0] yy,
                       input bit dd, input bit fz, input bit l, input logic [62:0] cf);
      exp_t ex;
      i_valid  = v;
      x        = xx;
      y        = yy;
      d        = dd;
      i_freeze = fz;
      i_load   = l;
      i_coeffs = cf;
      model_step(v, xx, yy, dd, fz, l, cf);
      @(posedge clkA);
      @(negedge clkA);
      ex = sb.pop_front();
      check("coeff",   64'(coeff),   64'(ex.c));
      check("e_out",   64'(e_out),   64'(ex.e));
      check("o_state", 64'(o_state), 64'(ex.s));
      check("o_sat",   64'(o_sat),   64'(ex.t));
   endtask

   task automatic idle_inputs();
      i_valid = 0; x = '0; y = '0; d = 1; i_freeze = 0; i_load = 0; i_coeffs = '0;
   endtask

   task automatic do_reset();
      idle_inputs();
      reset = 1'b0;
      repeat (2) @(posedge clkA);
      @(negedge clkA);
      sb.delete();
      model_reset();
      check("rst_coeff", 64'(coeff),   64'(RST_COEFF));
      check("rst_state", 64'(o_state), 64'd0);
      check("rst_e_out", 64'(e_out),   64'd0);
      check("rst_sat",   64'(o_sat),   64'd0);
      reset = 1'b1;
   endtask

   initial begin
      logic [62:0] all01, all3f, rc;
      logic [7:0]  yv;
      bit          v, fz, l;
      all01 = '0;
      all3f = '0;
      for (int k = 0; k < NW; k++) begin
         all01[k*NBW +: NBW] = 7'h01;
         all3f[k*NBW +: NBW] = 7'h3F;
      end
      fz = 0;

      // single update: e = 1.0, x_r[0] = 1.0, mu = 1/8
      do_reset();
      step(1, 8'h20, 8'h00, 1, 0, 0, '0);
      step(1, 8'h00, 8'h00, 1, 0, 0, '0);
      check("single_e_out", 64'(e_out), 64'h020);
      step(0, 8'h00, 8'h00, 1, 0, 0, '0);
      check("single_tap0",   64'(coeff[6:0]),   64'h04);
      check("single_center", 64'(coeff[34:28]), 64'h20);

      // e = 0: taps must hold exactly
      repeat (20) step(1, 8'($urandom), 8'h20, 1, 0, 0, '0);
      check("hold_tap0",   64'(coeff[6:0]),   64'h04);
      check("hold_center", 64'(coeff[34:28]), 64'h20);

      // ACQ step for e = 5.0, x = 1.0 is 0.625 -> tap 0x14
      do_reset();
      step(1, 8'h20, 8'h80, 1, 0, 0, '0);
      step(1, 8'h20, 8'h80, 1, 0, 0, '0);
      step(0, 8'h00, 8'h80, 1, 0, 0, '0);
      check("acq_step_tap0", 64'(coeff[6:0]), 64'h14);

      // ACQ -> TRACK after 1200 unfrozen valid samples; a freeze mid-way pauses the count
      do_reset();
      for (int i = 1; i <= 1200; i++) begin
         if (i == 400) begin
            repeat (30) step(1, 8'($urandom), 8'($urandom_range(0, 16)), 1, 1, 0, '0);
            check("acq_frz_state", 64'(o_state), 64'h2);
         end
         yv = 8'($urandom_range(0, 16));
         step(1, 8'($urandom_range(0, 15)), yv, 1, 0, 0, '0);
         if (i == 1199) check("acq_before", 64'(o_state), 64'h0);
      end
      check("acq_after", 64'(o_state), 64'h1);

      // TRACK: eight updates equal one ACQ step
      step(0, 8'h00, 8'h00, 1, 0, 1, '0);
      repeat (8) step(1, 8'h20, 8'h80, 1, 0, 0, '0);
      step(0, 8'h00, 8'h80, 1, 0, 0, '0);
      check("trk_4upd_tap0", 64'(coeff[6:0]), 64'h0A);
      repeat (8) step(1, 8'h20, 8'h80, 1, 0, 0, '0);
      step(0, 8'h00, 8'h80, 1, 0, 0, '0);
      check("trk_8upd_tap0", 64'(coeff[6:0]), 64'h14);
      check("trk_state",     64'(o_state),    64'h1);

      // saturation: large e*x drives every accumulator to the positive rail
      do_reset();
      repeat (30) step(1, 8'h7F, 8'h80, 1, 0, 0, '0);
      check("sat_coeff", 64'(coeff), 64'(all3f));
      check("sat_flag",  64'(o_sat), 64'h1);

      // debug load, then a long freeze
      step(0, 8'h00, 8'h00, 1, 0, 1, all01);
      step(0, 8'h00, 8'h00, 1, 0, 0, '0);
      check("load_coeff", 64'(coeff),   64'(all01));
      check("load_state", 64'(o_state), 64'h1);
      check("load_sat",   64'(o_sat),   64'h0);
      repeat (100) step(1, 8'($urandom), 8'($urandom), 1'($urandom), 1, 0, '0);
      check("frz_coeff", 64'(coeff),   64'(all01));
      check("frz_state", 64'(o_state), 64'h2);
      step(1, 8'h10, 8'h00, 1, 0, 0, '0);
      check("unfrz_state", 64'(o_state), 64'h1);

      // random mix incl. load+valid, load under freeze; freeze only moves with valid
      do_reset();
      for (int i = 0; i < 400; i++) begin
         v = ($urandom_range(0, 3) != 0);
         if (v && ($urandom_range(0, 7) == 0)) fz = ~fz;
         l = ($urandom_range(0, 49) == 0);
         rc = 63'({$urandom, $urandom});
         step(v, 8'($urandom), 8'($urandom), 1'($urandom), fz, l, rc);
      end

      // asynchronous reset between clock edges
      i_valid = 1; x = 8'h7F; y = 8'h80; d = 1; i_freeze = 0; i_load = 0;
      @(posedge clkA);
      #2 reset = 1'b0;
      #1;
      check("arst_coeff", 64'(coeff),   64'(RST_COEFF));
      check("arst_state", 64'(o_state), 64'h0);
      check("arst_e_out", 64'(e_out),   64'h0);
      check("arst_sat",   64'(o_sat),   64'h0);
      idle_inputs();
      @(negedge clkA);
      sb.delete();
      model_reset();
      reset = 1'b1;
      step(1, 8'h20, 8'h00, 1, 0, 0, '0);
      step(1, 8'h00, 8'h00, 1, 0, 0, '0);
      step(0, 8'h00, 8'h00, 1, 0, 0, '0);
      check("arst_rerun_tap0", 64'(coeff[6:0]), 64'h04);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
